// File: rtl/conv_pe_array.sv
// conv_pe_array: N processing elements sharing one stream of window pixels.
// Each PE holds its own K-tap signed filter and accumulates one window. At
// the end of the window it captures the sum. The N results are then
// quantised (arithmetic shift, optional ReLU, saturation) and sent out one
// at a time over a valid/ready port.
//
// Optional feature: define CONV_PE_RELU_EN to clamp negative results to 0
// before saturation.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   filt_we/pe/addr/data filter tap write; accepted only while busy=0
//   clr                  synchronous abort of the current window or drain
//   win_valid/ready/data pixel stream input
//   out_valid/ready      result stream handshake
//   out_data/out_pe      quantised result and its PE index
//   busy                 window in progress or results still pending
module conv_pe_array #(
  parameter int unsigned N     = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned K     = 9,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned SHIFT = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      filt_we,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]      filt_pe,
  input  logic [((K > 1) ? $clog2(K) : 1)-1:0]      filt_addr,
  input  logic signed [DW-1:0]                      filt_data,
  input  logic                                      clr,
  input  logic                                      win_valid,
  output logic                                      win_ready,
  input  logic signed [DW-1:0]                      win_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [DW-1:0]                      out_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]      out_pe,
  output logic                                      busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PRW = 2 * DW;

`ifdef CONV_PE_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  // Saturation bounds expressed at accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           t_q, t_d;
  logic [PW-1:0]           d_q, d_d;
  logic signed [DW-1:0]    filt_q [N][K];
  logic signed [DW-1:0]    filt_d [N][K];
  logic signed [ACC_W-1:0] acc_q  [N];
  logic signed [ACC_W-1:0] acc_d  [N];
  logic signed [ACC_W-1:0] res_q  [N];
  logic signed [ACC_W-1:0] res_d  [N];
  logic signed [PRW-1:0]   prod   [N];
  logic signed [ACC_W-1:0] sum    [N];

  logic busy_c;
  logic accept_c;
  logic last_tap_c;
  logic last_pe_c;
  logic wr_ok_c;

  // Shift, optional ReLU, then clamp to the signed DW-bit range
  function automatic logic signed [DW-1:0] quant(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] y;
    y = x >>> SHIFT;
    if (RELU_EN && (y < 0)) y = '0;
    if (y > SAT_MAX)      quant = SAT_MAX[DW-1:0];
    else if (y < SAT_MIN) quant = SAT_MIN[DW-1:0];
    else                  quant = y[DW-1:0];
  endfunction

  assign busy_c     = (t_q != '0) || (state_q == ST_DRAIN);
  assign accept_c   = win_valid && (state_q == ST_ACC);
  assign last_tap_c = (t_q == TW'(K - 1));
  assign last_pe_c  = (d_q == PW'(N - 1));
  assign wr_ok_c    = filt_we && !busy_c
                      && ({1'b0, filt_pe}   < (PW + 1)'(N))
                      && ({1'b0, filt_addr} < (TW + 1)'(K));

  // Per-PE product of the broadcast pixel and the current tap, plus running sum
  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod[i] = PRW'(win_data) * PRW'(filt_q[i][t_q]);
      sum[i]  = acc_q[i] + ACC_W'(prod[i]);
    end
  end

  // Next-state: filter store, accumulation, drain sequencing, clr override
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    d_d     = d_q;
    filt_d  = filt_q;
    acc_d   = acc_q;
    res_d   = res_q;

    if (wr_ok_c) filt_d[filt_pe][filt_addr] = filt_data;

    case (state_q)
      ST_ACC: begin
        if (accept_c) begin
          if (last_tap_c) begin
            res_d   = sum;
            for (int i = 0; i < N; i++) acc_d[i] = '0;
            t_d     = '0;
            d_d     = '0;
            state_d = ST_DRAIN;
          end else begin
            acc_d = sum;
            t_d   = t_q + TW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (last_pe_c) begin
            d_d     = '0;
            state_d = ST_ACC;
          end else begin
            d_d = d_q + PW'(1);
          end
        end
      end
      default: state_d = ST_ACC;
    endcase

    // Abort drops any pixel or result handshaking in the same cycle
    if (clr) begin
      t_d     = '0;
      d_d     = '0;
      for (int i = 0; i < N; i++) acc_d[i] = '0;
      state_d = ST_ACC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      t_q     <= '0;
      d_q     <= '0;
      for (int i = 0; i < N; i++) begin
        acc_q[i] <= '0;
        res_q[i] <= '0;
        for (int j = 0; j < K; j++) filt_q[i][j] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      d_q     <= d_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      filt_q  <= filt_d;
    end
  end

  // Outputs decode registered state only; data forced to 0 outside DRAIN
  assign win_ready = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_pe    = d_q;
  assign out_data  = (state_q == ST_DRAIN) ? quant(res_q[d_q]) : '0;
  assign busy      = busy_c;

endmodule

// File: tb/tb_conv_pe_array.sv
// Directed bench for conv_pe_array: a default instance (SHIFT=0) and a
// SHIFT=8 instance share all inputs; expected results are hand-computed.
module tb_conv_pe_array;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2;
  localparam int unsigned TW = 4;

  logic                 clk, rst, filt_we, clr, win_valid, out_ready;
  logic [PW-1:0]        filt_pe;
  logic [TW-1:0]        filt_addr;
  logic signed [DW-1:0] filt_data, win_data;

  logic                 win_ready, out_valid, busy;
  logic signed [DW-1:0] out_data;
  logic [PW-1:0]        out_pe;
  logic                 s_win_ready, s_out_valid, s_busy;
  logic signed [DW-1:0] s_out_data;
  logic [PW-1:0]        s_out_pe;

  int n_pass   = 0;
  int n_checks = 0;

  typedef integer exp_t [4];
  exp_t ea, es;
  integer neg_sat;

  conv_pe_array #(.N(4), .DW(8), .K(9), .ACC_W(20), .SHIFT(0)) u_dut (
    .clk(clk), .rst(rst), .filt_we(filt_we), .filt_pe(filt_pe),
    .filt_addr(filt_addr), .filt_data(filt_data), .clr(clr),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pe(out_pe), .busy(busy)
  );

  conv_pe_array #(.N(4), .DW(8), .K(9), .ACC_W(20), .SHIFT(8)) u_dut_s (
    .clk(clk), .rst(rst), .filt_we(filt_we), .filt_pe(filt_pe),
    .filt_addr(filt_addr), .filt_data(filt_data), .clr(clr),
    .win_valid(win_valid), .win_ready(s_win_ready), .win_data(win_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_pe(s_out_pe), .busy(s_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input integer obs, input integer exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".win_ready"}, win_ready, 1);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".out_data"},  out_data,  0);
    check({tag, ".out_pe"},    out_pe,    0);
    check({tag, ".busy"},      busy,      0);
    check({tag, ".s_busy"},    s_busy,    0);
  endtask

  task automatic wr(input int pe, input int addr, input int val);
    filt_we   = 1'b1;
    filt_pe   = PW'(pe);
    filt_addr = TW'(addr);
    filt_data = DW'(val);
    @(negedge clk);
    filt_we   = 1'b0;
  endtask

  task automatic load_ramp();
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 9; a++) wr(p, a, p + 1);
  endtask

  task automatic load_all(input int val);
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 9; a++) wr(p, a, val);
  endtask

  task automatic send(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      win_valid = 1'b1;
      win_data  = DW'(val);
      @(negedge clk);
    end
    win_valid = 1'b0;
  endtask

  // Expects DRAIN at d=0 now and out_ready=1; walks all PEs then checks ACC
  task automatic drain_expect(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s.pe%0d.valid", tag, i),    out_valid,   1);
      check($sformatf("%s.pe%0d.idx", tag, i),      out_pe,      i);
      check($sformatf("%s.pe%0d.data", tag, i),     out_data,    ea[i]);
      check($sformatf("%s.pe%0d.win_ready", tag, i), win_ready,  0);
      check($sformatf("%s.pe%0d.s_valid", tag, i),  s_out_valid, 1);
      check($sformatf("%s.pe%0d.s_idx", tag, i),    s_out_pe,    i);
      check($sformatf("%s.pe%0d.s_data", tag, i),   s_out_data,  es[i]);
      @(negedge clk);
    end
    check({tag, ".done.win_ready"},   win_ready,   1);
    check({tag, ".done.out_valid"},   out_valid,   0);
    check({tag, ".done.s_win_ready"}, s_win_ready, 1);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; filt_we = 1'b0; clr = 1'b0;
    win_valid = 1'b0; out_ready = 1'b1;
    filt_pe = '0; filt_addr = '0; filt_data = '0; win_data = '0;
`ifdef CONV_PE_RELU_EN
    neg_sat = 0;
`else
    neg_sat = -128;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    // PE i weights i+1, pixels 2: 9*2*(i+1)
    load_ramp();
    send(2, 9);
    ea = '{18, 36, 54, 72}; es = '{0, 0, 0, 0};
    drain_expect("ramp");

    // Positive and negative saturation
    load_all(127);
    send(127, 9);
    ea = '{127, 127, 127, 127}; es = '{127, 127, 127, 127};
    drain_expect("sat_pos");
    send(-128, 9);
    ea = '{neg_sat, neg_sat, neg_sat, neg_sat};
    es = '{neg_sat, neg_sat, neg_sat, neg_sat};
    drain_expect("sat_neg");

    // 9*16*16 = 2304: saturates at SHIFT=0, 2304>>8 = 9 at SHIFT=8
    load_all(16);
    send(16, 9);
    ea = '{127, 127, 127, 127}; es = '{9, 9, 9, 9};
    drain_expect("shift");

    // Backpressure held on PE0 for 5 cycles
    load_ramp();
    send(3, 9);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp.c%0d.valid", c),     out_valid, 1);
      check($sformatf("bp.c%0d.idx", c),       out_pe,    0);
      check($sformatf("bp.c%0d.data", c),      out_data,  27);
      check($sformatf("bp.c%0d.win_ready", c), win_ready, 0);
    end
    out_ready = 1'b1;
    ea = '{27, 54, 81, 108}; es = '{0, 0, 0, 0};
    drain_expect("bp_release");

    // Async reset mid-window wipes filters too
    send(1, 4);
    check("rst_mid.busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check_idle("rst_mid.async");
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid.after");
    send(5, 9);
    ea = '{0, 0, 0, 0}; es = '{0, 0, 0, 0};
    drain_expect("rst_zero_filt");

    // clr after 4 pixels discards the partial sums
    load_ramp();
    send(7, 4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr.busy", busy, 0);
    check("clr.win_ready", win_ready, 1);
    send(1, 9);
    ea = '{9, 18, 27, 36}; es = '{0, 0, 0, 0};
    drain_expect("clr_fresh");

    // Write while busy is ignored for this and the next window
    send(1, 4);
    check("guard.busy", busy, 1);
    wr(0, 0, 50);
    send(1, 5);
    drain_expect("guard_cur");
    send(1, 9);
    drain_expect("guard_next");
    check("guard.idle_busy", busy, 0);
    wr(0, 0, 50);
    send(1, 9);
    ea = '{58, 18, 27, 36};
    drain_expect("guard_new");

    // clr together with the 9th pixel: no drain
    send(1, 8);
    win_valid = 1'b1; win_data = 8'sd1; clr = 1'b1;
    @(negedge clk);
    win_valid = 1'b0; clr = 1'b0;
    check("sim.out_valid", out_valid, 0);
    check("sim.busy", busy, 0);
    check("sim.win_ready", win_ready, 1);
    @(negedge clk);
    check("sim.out_valid2", out_valid, 0);
    send(2, 9);
    ea = '{116, 36, 54, 72};
    drain_expect("sim_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_pe_array.md
# conv_pe_array

Parametrised processing-element array for the CNN accelerator; the next generation of the fixed per-PE MAC datapath. It broadcasts one stream of window pixels to N PEs, each holding its own K-tap signed filter. It accumulates one convolution window per PE, then quantises and saturates each result. The N results are serialised over a valid/ready port to the OFM writer. It sits between the window shift buffer (upstream) and OFM memory (downstream).

## Interface
- N, 4, number of PEs (filters processed in parallel), ≥1
- DW, 8, signed pixel/weight/result width
- K, 9, taps per window (3×3)
- ACC_W, 20, signed accumulator width; must be ≥ 2·DW + ceil(log2 K)
- SHIFT, 0, arithmetic right shift applied to accumulator before saturation
- Localparams: PW = max(1, clog2(N)); TW = max(1, clog2(K))
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- filt_we  in  1  filter-tap write strobe
- filt_pe  in  PW  target PE for filter write
- filt_addr  in  TW  tap index for filter write
- filt_data  in  DW  signed weight
- clr  in  1  synchronous abort of current window
- win_valid  in  1  window pixel valid
- win_ready  out  1  array accepts pixel
- win_data  in  DW  signed pixel
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  signed quantised result
- out_pe  out  PW  PE index of out_data
- busy  out  1  window in progress or results pending

## Operation
- State machine with two states: ACC and DRAIN. Reset state is ACC.
- Filter store: N×K signed DW registers, reset to 0.
  - filt_we writes filt_data to [filt_pe][filt_addr] only when busy=0.
  - Writes while busy=1 are ignored, as are writes with filt_pe ≥ N or filt_addr ≥ K.
- ACC state:
  - win_ready=1.
  - Each accept (win_valid & win_ready) at tap t updates every PE: acc_i ← acc_i + sext(win_data·filt[i][t]). The product is 2·DW signed; the sum wraps modulo 2^ACC_W.
  - t increments on each accept.
  - On the accept with t=K−1, every acc_i + product_i is captured into res_i. acc_i and t clear to 0, and the state moves to DRAIN.
- DRAIN state:
  - win_ready=0; drain counter d starts at 0.
  - out_valid=1, out_pe=d, out_data=q(res_d).
  - Each out handshake increments d. The handshake at d=N−1 returns the state to ACC.
- Quantisation q(x): y = x >>> SHIFT (arithmetic); then saturate y to [−2^(DW−1), 2^(DW−1)−1].
- busy = (t≠0) | (state==DRAIN).
- clr (synchronous):
  - Clears t, all acc_i and d, and sets the state to ACC. Filters are unaffected.
  - clr wins over a simultaneous pixel accept or out handshake; that pixel or result is dropped.
- Async rst clears all state, including filters, at any time, including mid-window or mid-drain.

## Timing
- Reset values: win_ready=1, out_valid=0, out_data=0, out_pe=0, busy=0.
- Pixel throughput: 1 per cycle in ACC; no bubbles between windows beyond the drain.
- Latency: last tap accepted at edge T → out_valid=1 with out_pe=0 after edge T (visible in cycle T+1).
- Drain takes N cycles minimum with out_ready held high. win_ready rises the cycle after the final handshake.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_pe are held stable.
- Filter write takes effect for the next accepted pixel.

## Configuration
- CONV_PE_RELU_EN:
  - Defined: ReLU is applied after the shift and before saturation (y<0 → 0), so out_data ∈ [0, 2^(DW−1)−1].
  - Undefined: no ReLU; signed saturated output.

## Test plan
- Defaults, SHIFT=0: PE i taps all = i+1; 9 pixels of value 2 → out_pe 0..3 gives out_data 18, 36, 54, 72; out_valid high 4 cycles with out_ready=1.
- Saturation: all taps 127, pixels 127 → 127; pixels −128 → −128 (ReLU off) or 0 (ReLU on). SHIFT=8 with 9 pixels of 16 and all taps 16 → 9.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DRAIN → out_valid stays 1, out_data and out_pe stable, win_ready=0.
  - Release → remaining PEs drain in order, then win_ready=1.
- Mid-window events:
  - rst after 4 accepted pixels → all outputs at reset values and filters at 0; a following window yields all results 0.
  - clr after 4 pixels → next 9 pixels produce correct fresh results.
- Write guard: filt_we while busy=1 → current and next window use the old weights. filt_we with busy=0 → the new weight is used.
- Simultaneous: clr with win_valid=1 on the 9th pixel → no DRAIN entered, t=0, out_valid stays 0.
